// File: rtl/card_layout_if.sv
// Valid/ready stream of card slot positions.
// Producer drives {y,x}, index and last flag; consumer drives ready.
interface card_layout_if #(
   parameter int COORD_W = 10,
   parameter int IDX_W   = 5
);
   logic                   pos_valid;
   logic                   pos_ready;
   logic [2*COORD_W-1:0]   pos_yx;
   logic [IDX_W-1:0]       pos_idx;
   logic                   pos_last;

   modport master (
      output pos_valid, pos_yx, pos_idx, pos_last,
      input  pos_ready
   );

   modport slave (
      input  pos_valid, pos_yx, pos_idx, pos_last,
      output pos_ready
   );
endinterface

// File: rtl/card_layout_gen.sv
// Streams the top-left {y,x} of every card slot for the chosen mode.
// Coordinates are accumulated from origin and pitch, never multiplied.
module card_layout_gen #(
   parameter int COORD_W   = 10,
   parameter int IDX_W     = 5,
   parameter int COLS      = 4,
   parameter int X0        = 50,
   parameter int X_PITCH   = 258,
   parameter int ROWS_E    = 2,
   parameter int Y0_E      = 50,
   parameter int Y_PITCH_E = 368,
   parameter int ROWS_N    = 3,
   parameter int Y0_N      = 50,
   parameter int Y_PITCH_N = 234,
   parameter int ROWS_H    = 4,
   parameter int Y0_H      = 25,
   parameter int Y_PITCH_H = 175
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [1:0]         mode_i,
   output logic [IDX_W-1:0]   num_cards_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   card_layout_if.master      pos
);

   localparam int AW = COORD_W + 1;
   localparam logic [AW-1:0]    X0_A     = AW'(X0);
   localparam logic [AW-1:0]    XP_A     = AW'(X_PITCH);
   localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);

   if (COLS * ROWS_E > 2**IDX_W || COLS * ROWS_N > 2**IDX_W ||
       COLS * ROWS_H > 2**IDX_W) begin : g_bad_idx_w
      $error("card_layout_gen: COLS*ROWS exceeds 2**IDX_W");
   end

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     rows_q, col_q, row_q, idx_q, num_q;
   logic [AW-1:0]        x_q, y_q, yp_q;
   logic [2*COORD_W-1:0] yx_q;
   logic                 valid_q, last_q, busy_q, done_q, err_q;

   logic [IDX_W-1:0]     sel_rows, sel_num, ncol, nrow;
   logic [AW-1:0]        sel_y0, sel_yp, nx, ny;
   logic                 wrap, nlast, first_last;

   function automatic logic [COORD_W-1:0] sat(input logic [AW-1:0] v);
      return v[COORD_W] ? '1 : v[COORD_W-1:0];
   endfunction

   always_comb begin
      sel_rows = '0;
      sel_num  = '0;
      sel_y0   = '0;
      sel_yp   = '0;
      unique case (mode_i)
         2'd0: begin
            sel_rows = IDX_W'(ROWS_E);
            sel_num  = IDX_W'(COLS * ROWS_E);
            sel_y0   = AW'(Y0_E);
            sel_yp   = AW'(Y_PITCH_E);
         end
         2'd1: begin
            sel_rows = IDX_W'(ROWS_N);
            sel_num  = IDX_W'(COLS * ROWS_N);
            sel_y0   = AW'(Y0_N);
            sel_yp   = AW'(Y_PITCH_N);
         end
         2'd2: begin
            sel_rows = IDX_W'(ROWS_H);
            sel_num  = IDX_W'(COLS * ROWS_H);
            sel_y0   = AW'(Y0_H);
            sel_yp   = AW'(Y_PITCH_H);
         end
         default: ;
      endcase
   end

   always_comb begin
      wrap  = (col_q == COL_LAST);
      ncol  = wrap ? '0 : col_q + IDX_W'(1);
      nrow  = wrap ? row_q + IDX_W'(1) : row_q;
      nx    = wrap ? X0_A : x_q + XP_A;
      ny    = wrap ? y_q + yp_q : y_q;
      nlast = (nrow == rows_q - IDX_W'(1)) && (ncol == COL_LAST);
      first_last = (sel_rows == IDX_W'(1)) && (COL_LAST == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rows_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         yp_q    <= '0;
         yx_q    <= '1;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // abort outranks start even though it is otherwise a no-op here
               if (start_i && !abort_i) begin
                  if (mode_i == 2'd3) begin
                     err_q <= 1'b1;
                     num_q <= '0;
                  end else begin
                     rows_q  <= sel_rows;
                     yp_q    <= sel_yp;
                     num_q   <= sel_num;
                     x_q     <= X0_A;
                     y_q     <= sel_y0;
                     col_q   <= '0;
                     row_q   <= '0;
                     idx_q   <= '0;
                     yx_q    <= {sat(sel_y0), sat(X0_A)};
                     last_q  <= first_last;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (abort_i || (pos.pos_ready && last_q)) begin
                  done_q  <= !abort_i;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  yx_q    <= '1;
                  idx_q   <= '0;
                  state_q <= IDLE;
               end else if (pos.pos_ready) begin
                  col_q  <= ncol;
                  row_q  <= nrow;
                  x_q    <= nx;
                  y_q    <= ny;
                  idx_q  <= idx_q + IDX_W'(1);
                  yx_q   <= {sat(ny), sat(nx)};
                  last_q <= nlast;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pos.pos_valid = valid_q;
   assign pos.pos_yx    = yx_q;
   assign pos.pos_idx   = idx_q;
   assign pos.pos_last  = last_q;
   assign num_cards_o   = num_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule
